// File: rtl/spawn_scheduler.sv
// spawn_scheduler
//   Turns the game PRNG word into periodic trash-spawn requests on a grid.
//   A free-running frame-tick counter opens one spawn attempt every PERIOD
//   ticks. During an attempt one rand_in sample is taken per clock. Samples
//   that fall outside the grid are retried, up to RETRY_LIMIT samples. An
//   accepted coordinate is offered to the object manager. The number of live
//   objects is tracked so that no more than MAX_ACTIVE exist at once.
//
// Handshake: spawn_valid rises with stable spawn_x/spawn_y. Both hold until a
//   clock edge samples spawn_valid & spawn_ready, which completes the transfer.
//   The request is never withdrawn (not even by enable=0). spawn_ready is
//   ignored while spawn_valid=0.
//
// Ports:
//   clk, reset     clock; asynchronous active-high reset
//   enable         level, 1 = scheduling runs
//   tick           one-clock frame pulse
//   rand_in[15:0]  PRNG word: x = [5:0], y = [10:6], [15:11] unused
//   spawn_valid    request pending (out)
//   spawn_ready    object manager accepts the request (in)
//   spawn_x[5:0]   spawn column (out)
//   spawn_y[4:0]   spawn row (out)
//   collected      one-clock pulse: one live object was removed
//   active_count   live spawned objects (out)
//   spawn_skip     one-clock pulse: the period expired while full
//   retry_fail     one-clock pulse: RETRY_LIMIT samples were all off-grid
//   dbg_state[1:0] FSM state: 0 IDLE, 1 WAIT, 2 SAMPLE, 3 OFFER
module spawn_scheduler #(
   parameter int GRID_W      = 40,
   parameter int GRID_H      = 30,
   parameter int PERIOD      = 60,
   parameter int MAX_ACTIVE  = 8,
   parameter int RETRY_LIMIT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        tick,
   input  logic [15:0] rand_in,
   output logic        spawn_valid,
   input  logic        spawn_ready,
   output logic [5:0]  spawn_x,
   output logic [4:0]  spawn_y,
   input  logic        collected,
   output logic [3:0]  active_count,
   output logic        spawn_skip,
   output logic        retry_fail,
   output logic [1:0]  dbg_state
);

   localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int RW = (RETRY_LIMIT > 1) ? $clog2(RETRY_LIMIT) : 1;
   localparam logic [TW-1:0] TICK_LAST  = TW'(PERIOD - 1);
   localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY_LIMIT - 1);
   localparam logic [3:0]    MAX_CNT    = 4'(MAX_ACTIVE);
   localparam logic [6:0]    GRID_W_L   = 7'(GRID_W);
   localparam logic [5:0]    GRID_H_L   = 6'(GRID_H);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_SAMPLE = 2'd2,
      S_OFFER  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
   logic [RW-1:0]   retry_cnt_q, retry_cnt_d;
   logic [5:0]      x_q, x_d;
   logic [4:0]      y_q, y_d;
   logic [3:0]      count_q, count_d;
   logic            skip_q, skip_d;
   logic            fail_q, fail_d;

   logic [5:0]      cand_x;
   logic [4:0]      cand_y;
   logic            cand_ok;
   logic            expire;
   logic            full;
   logic            handshake;
   logic            unused_rand_hi;

   assign cand_x         = rand_in[5:0];
   assign cand_y         = rand_in[10:6];
   assign unused_rand_hi = ^rand_in[15:11];
   assign cand_ok        = ({1'b0, cand_x} < GRID_W_L) && ({1'b0, cand_y} < GRID_H_L);
   assign expire         = tick && (tick_cnt_q == TICK_LAST);
   assign full           = (count_q >= MAX_CNT);
   // spawn_valid is the OFFER state itself, so reset drops it at once.
   assign handshake      = (state_q == S_OFFER) && spawn_ready;

   // State register and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         tick_cnt_q  <= '0;
         retry_cnt_q <= '0;
         x_q         <= '0;
         y_q         <= '0;
         count_q     <= '0;
         skip_q      <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         retry_cnt_q <= retry_cnt_d;
         x_q         <= x_d;
         y_q         <= y_d;
         count_q     <= count_d;
         skip_q      <= skip_d;
         fail_q      <= fail_d;
      end
   end

   // Next-state logic, including the tick and retry counters.
   always_comb begin
      state_d     = state_q;
      tick_cnt_d  = tick_cnt_q;
      retry_cnt_d = retry_cnt_q;
      // The period counter runs through WAIT, SAMPLE and OFFER alike; only
      // WAIT acts on an expiry, so an expiry elsewhere is simply lost.
      if (tick) begin
         tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TW'(1);
      end
      case (state_q)
         S_IDLE: begin
            tick_cnt_d = '0;
            if (enable) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (!enable) begin
               state_d    = S_IDLE;
               tick_cnt_d = '0;
            end else if (expire && !full) begin
               state_d     = S_SAMPLE;
               retry_cnt_d = '0;
            end
         end
         S_SAMPLE: begin
            if (!enable) begin
               state_d    = S_IDLE;
               tick_cnt_d = '0;
            end else if (cand_ok) begin
               state_d = S_OFFER;
            end else if (retry_cnt_q == RETRY_LAST) begin
               state_d = S_WAIT;
            end else begin
               retry_cnt_d = retry_cnt_q + RW'(1);
            end
         end
         S_OFFER: begin
            // A pending request always completes; enable is only looked at
            // once the transfer happens.
            if (handshake) begin
               if (enable) begin
                  state_d = S_WAIT;
               end else begin
                  state_d    = S_IDLE;
                  tick_cnt_d = '0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Registered outputs: coordinates, live count and status pulses.
   always_comb begin
      x_d     = x_q;
      y_d     = y_q;
      count_d = count_q;
      skip_d  = (state_q == S_WAIT) && enable && expire && full;
      fail_d  = (state_q == S_SAMPLE) && enable && !cand_ok && (retry_cnt_q == RETRY_LAST);
      if ((state_q == S_SAMPLE) && enable && cand_ok) begin
         x_d = cand_x;
         y_d = cand_y;
      end
      // A spawn and a collection in the same clock cancel out.
      if (handshake && !collected) begin
         count_d = count_q + 4'd1;
      end else if (!handshake && collected && (count_q != 4'd0)) begin
         count_d = count_q - 4'd1;
      end
   end

   assign spawn_valid  = (state_q == S_OFFER);
   assign spawn_x      = x_q;
   assign spawn_y      = y_q;
   assign active_count = count_q;
   assign spawn_skip   = skip_q;
   assign retry_fail   = fail_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Bench for spawn_scheduler with PERIOD=2, MAX_ACTIVE=2, RETRY_LIMIT=16.
// A behavioural model tracks the scheduler in terms of "running / sampling /
// offering" flags, the tick phase and the number of live objects. Accepted
// coordinates go into exp_q and leave it when the transfer completes.
module tb_spawn_scheduler;

   localparam int P    = 2;
   localparam int MAXA = 2;
   localparam int RL   = 16;
   localparam int GW   = 40;
   localparam int GH   = 30;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        tick = 1'b0;
   logic [15:0] rand_in = 16'h0;
   logic        spawn_ready = 1'b0;
   logic        collected = 1'b0;
   logic        spawn_valid;
   logic [5:0]  spawn_x;
   logic [4:0]  spawn_y;
   logic [3:0]  active_count;
   logic        spawn_skip;
   logic        retry_fail;
   logic [1:0]  dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state.
   bit          m_on, m_samp, m_offer;
   int          m_ph, m_tries, m_live;
   bit          m_skip, m_fail;
   logic [10:0] exp_q[$];

   always #5 clk = ~clk;

   spawn_scheduler #(
      .GRID_W(GW), .GRID_H(GH), .PERIOD(P), .MAX_ACTIVE(MAXA), .RETRY_LIMIT(RL)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .tick(tick), .rand_in(rand_in),
      .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
      .spawn_x(spawn_x), .spawn_y(spawn_y), .collected(collected),
      .active_count(active_count), .spawn_skip(spawn_skip),
      .retry_fail(retry_fail), .dbg_state(dbg_state)
   );

   function automatic logic [1:0] exp_dbg();
      if (m_offer) return 2'd3;
      if (m_samp)  return 2'd2;
      if (m_on)    return 2'd1;
      return 2'd0;
   endfunction

   task automatic model_reset();
      m_on = 0; m_samp = 0; m_offer = 0;
      m_ph = 0; m_tries = 0; m_live = 0;
      m_skip = 0; m_fail = 0;
      exp_q.delete();
   endtask

   // Advance model and DUT by one clock with the inputs currently driven.
   task automatic step();
      bit n_on, n_samp, n_offer, n_skip, n_fail, hs, expired, ok, do_push, do_pop;
      int n_ph, n_tries, n_live, cx, cy;
      cx = int'(rand_in[5:0]);
      cy = int'(rand_in[10:6]);
      ok = (cx < GW) && (cy < GH);
      hs = m_offer && spawn_ready;
      expired = tick && (m_ph == P - 1);
      n_on = m_on; n_samp = m_samp; n_offer = m_offer;
      n_ph = tick ? (m_ph + 1) % P : m_ph;
      n_tries = m_tries; n_live = m_live;
      n_skip = 0; n_fail = 0; do_push = 0; do_pop = 0;
      if (!m_on && !m_samp && !m_offer) begin
         n_ph = 0;
         if (enable) n_on = 1;
      end else if (m_on) begin
         if (!enable) begin n_on = 0; n_ph = 0; end
         else if (expired) begin
            if (m_live >= MAXA) n_skip = 1;
            else begin n_on = 0; n_samp = 1; n_tries = 0; end
         end
      end else if (m_samp) begin
         if (!enable) begin n_samp = 0; n_ph = 0; end
         else if (ok) begin n_samp = 0; n_offer = 1; do_push = 1; end
         else if (m_tries == RL - 1) begin n_samp = 0; n_on = 1; n_fail = 1; end
         else n_tries = m_tries + 1;
      end else if (spawn_ready) begin
         n_offer = 0; do_pop = 1;
         if (enable) n_on = 1;
         else n_ph = 0;
      end
      if (hs && !collected) n_live = m_live + 1;
      else if (!hs && collected && m_live > 0) n_live = m_live - 1;
      @(posedge clk);
      if (do_pop && exp_q.size() > 0) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({cx[5:0], cy[4:0]});
      m_on = n_on; m_samp = n_samp; m_offer = n_offer; m_ph = n_ph;
      m_tries = n_tries; m_live = n_live; m_skip = n_skip; m_fail = n_fail;
      #1;
   endtask

   task automatic pulse_tick();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   // Keep ticking until the model is offering; returns 0 if the bound runs out.
   task automatic run_to_offer(output bit reached);
      for (int i = 0; i < 8 && !m_offer; i++) begin
         tick = 1'b1;
         step();
      end
      tick = 1'b0;
      reached = m_offer;
   endtask

   function automatic logic [15:0] in_grid_word(input int x, input int y);
      logic [4:0] hi;
      hi = 5'($urandom_range(0, 31));
      return {hi, 5'(y), 6'(x)};
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      model_reset();
      step();
      step();
      n_tests++; if (spawn_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b exp 0", spawn_valid); end
      n_tests++; if (spawn_x !== 6'd0 || spawn_y !== 5'd0) begin n_fail++; $display("FAIL reset_xy: got %0d,%0d exp 0,0", spawn_x, spawn_y); end
      n_tests++; if (active_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", active_count); end
      n_tests++; if (spawn_skip !== 1'b0 || retry_fail !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got skip=%0b fail=%0b exp 0,0", spawn_skip, retry_fail); end
      n_tests++; if (dbg_state !== exp_dbg()) begin n_fail++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, exp_dbg()); end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      enable = 1'b1; rand_in = 16'h0145; spawn_ready = 1'b1;
      step();
      pulse_tick();
      n_tests++; if (spawn_valid !== 1'b0 || dbg_state !== exp_dbg()) begin n_fail++; $display("FAIL basic_wait: got valid=%0b state=%0d exp 0,%0d", spawn_valid, dbg_state, exp_dbg()); end
      pulse_tick();
      n_tests++; if (spawn_valid !== 1'b0 || dbg_state !== 2'd2) begin n_fail++; $display("FAIL basic_sample: got valid=%0b state=%0d exp 0,2", spawn_valid, dbg_state); end
      step();
      n_tests++; if (spawn_valid !== 1'b1 || spawn_x !== 6'd5 || spawn_y !== 5'd5) begin n_fail++; $display("FAIL basic_offer: got v=%0b x=%0d y=%0d exp 1,5,5", spawn_valid, spawn_x, spawn_y); end
      n_tests++; if (exp_q.size() != 1 || {spawn_x, spawn_y} !== exp_q[0]) begin n_fail++; $display("FAIL basic_sb: got %h exp %h", {spawn_x, spawn_y}, (exp_q.size() > 0) ? exp_q[0] : 11'h0); end
      step();
      n_tests++; if (spawn_valid !== 1'b0 || active_count !== 4'd1) begin n_fail++; $display("FAIL basic_done: got v=%0b count=%0d exp 0,1", spawn_valid, active_count); end
   endtask

   task automatic test_retry();
      collected = 1'b1; step(); collected = 1'b0;
      n_tests++; if (active_count !== 4'(m_live)) begin n_fail++; $display("FAIL retry_collect: got %0d exp %0d", active_count, m_live); end
      rand_in = 16'h0028;
      for (int i = 0; i < 4 && !m_samp; i++) pulse_tick();
      n_tests++; if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL retry_enter: got state %0d exp 2", dbg_state); end
      for (int k = 0; k < 3; k++) begin
         step();
         n_tests++; if (spawn_valid !== 1'b0 || retry_fail !== 1'b0) begin n_fail++; $display("FAIL retry_reject%0d: got v=%0b f=%0b exp 0,0", k, spawn_valid, retry_fail); end
      end
      rand_in = 16'h0767;
      step();
      n_tests++; if (spawn_valid !== 1'b1 || spawn_x !== 6'd39 || spawn_y !== 5'd29 || retry_fail !== 1'b0) begin n_fail++; $display("FAIL retry_accept: got v=%0b x=%0d y=%0d f=%0b exp 1,39,29,0", spawn_valid, spawn_x, spawn_y, retry_fail); end
      step();
      n_tests++; if (active_count !== 4'(m_live) || spawn_valid !== 1'b0) begin n_fail++; $display("FAIL retry_done: got count=%0d v=%0b exp %0d,0", active_count, spawn_valid, m_live); end
   endtask

   task automatic test_retry_fail();
      int pulses;
      pulses = 0;
      rand_in = 16'h0028;
      for (int i = 0; i < 4 && !m_samp; i++) pulse_tick();
      for (int k = 0; k < RL; k++) begin
         step();
         if (retry_fail === 1'b1) pulses++;
         n_tests++; if (retry_fail !== m_fail || spawn_valid !== 1'b0) begin n_fail++; $display("FAIL rfail_step%0d: got f=%0b v=%0b exp %0b,0", k, retry_fail, spawn_valid, m_fail); end
      end
      n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL rfail_pulses: got %0d exp 1", pulses); end
      n_tests++; if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL rfail_state: got %0d exp 1", dbg_state); end
      step();
      n_tests++; if (retry_fail !== 1'b0) begin n_fail++; $display("FAIL rfail_clear: got %0b exp 0", retry_fail); end
   endtask

   task automatic test_offer_hold();
      bit reached;
      spawn_ready = 1'b0; rand_in = 16'h0145;
      run_to_offer(reached);
      n_tests++; if (!reached || spawn_valid !== 1'b1) begin n_fail++; $display("FAIL hold_reach: got v=%0b exp 1", spawn_valid); end
      enable = 1'b0;
      for (int k = 0; k < 10; k++) begin
         rand_in = 16'($urandom);
         tick = 1'($urandom_range(0, 1));
         step();
         n_tests++; if (spawn_valid !== 1'b1 || spawn_x !== 6'd5 || spawn_y !== 5'd5) begin n_fail++; $display("FAIL hold_cyc%0d: got v=%0b x=%0d y=%0d exp 1,5,5", k, spawn_valid, spawn_x, spawn_y); end
      end
      tick = 1'b0;
      spawn_ready = 1'b1;
      step();
      n_tests++; if (spawn_valid !== 1'b0 || active_count !== 4'd2 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL hold_done: got v=%0b count=%0d state=%0d exp 0,2,0", spawn_valid, active_count, dbg_state); end
   endtask

   task automatic test_full_skip();
      bit reached;
      int x, y;
      enable = 1'b1; spawn_ready = 1'b1;
      step();
      pulse_tick();
      pulse_tick();
      n_tests++; if (spawn_skip !== 1'b1 || spawn_valid !== 1'b0 || dbg_state !== 2'd1) begin n_fail++; $display("FAIL skip_pulse: got s=%0b v=%0b state=%0d exp 1,0,1", spawn_skip, spawn_valid, dbg_state); end
      step();
      n_tests++; if (spawn_skip !== 1'b0) begin n_fail++; $display("FAIL skip_clear: got %0b exp 0", spawn_skip); end
      collected = 1'b1; step(); collected = 1'b0;
      n_tests++; if (active_count !== 4'd1) begin n_fail++; $display("FAIL skip_collect: got %0d exp 1", active_count); end
      x = $urandom_range(0, GW - 1); y = $urandom_range(0, GH - 1);
      rand_in = in_grid_word(x, y);
      spawn_ready = 1'b0;
      run_to_offer(reached);
      n_tests++; if (!reached || spawn_x !== 6'(x) || spawn_y !== 5'(y)) begin n_fail++; $display("FAIL skip_respawn: got x=%0d y=%0d exp %0d,%0d", spawn_x, spawn_y, x, y); end
      spawn_ready = 1'b1; step();
      n_tests++; if (active_count !== 4'd2) begin n_fail++; $display("FAIL skip_refill: got %0d exp 2", active_count); end
      collected = 1'b1; step(); collected = 1'b0;
      spawn_ready = 1'b0;
      rand_in = in_grid_word($urandom_range(0, GW - 1), $urandom_range(0, GH - 1));
      run_to_offer(reached);
      spawn_ready = 1'b1; collected = 1'b1;
      step();
      collected = 1'b0;
      n_tests++; if (active_count !== 4'd1 || spawn_valid !== 1'b0) begin n_fail++; $display("FAIL skip_cancel: got count=%0d v=%0b exp 1,0", active_count, spawn_valid); end
   endtask

   task automatic test_reset_offer();
      bit reached;
      int x, y;
      spawn_ready = 1'b0;
      x = $urandom_range(1, GW - 1); y = $urandom_range(1, GH - 1);
      rand_in = in_grid_word(x, y);
      run_to_offer(reached);
      n_tests++; if (!reached || spawn_valid !== 1'b1) begin n_fail++; $display("FAIL rst_offer_reach: got v=%0b exp 1", spawn_valid); end
      #2 reset = 1'b1;
      #1;
      model_reset();
      n_tests++; if (spawn_valid !== 1'b0 || active_count !== 4'd0) begin n_fail++; $display("FAIL rst_offer_drop: got v=%0b count=%0d exp 0,0", spawn_valid, active_count); end
      n_tests++; if (spawn_x !== 6'd0 || spawn_y !== 5'd0) begin n_fail++; $display("FAIL rst_offer_xy: got %0d,%0d exp 0,0", spawn_x, spawn_y); end
      enable = 1'b0;
      step();
      reset = 1'b0; enable = 1'b1; spawn_ready = 1'b1;
      step();
      pulse_tick();
      n_tests++; if (dbg_state !== 2'd1 || spawn_valid !== 1'b0) begin n_fail++; $display("FAIL rst_offer_wait: got state=%0d v=%0b exp 1,0", dbg_state, spawn_valid); end
      pulse_tick();
      step();
      n_tests++; if (spawn_valid !== 1'b1 || spawn_x !== 6'(x) || spawn_y !== 5'(y)) begin n_fail++; $display("FAIL rst_offer_again: got v=%0b x=%0d y=%0d exp 1,%0d,%0d", spawn_valid, spawn_x, spawn_y, x, y); end
      step();
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         enable      = ($urandom_range(0, 19) != 0);
         tick        = ($urandom_range(0, 3) == 0);
         rand_in     = 16'($urandom);
         spawn_ready = 1'($urandom_range(0, 1));
         collected   = ($urandom_range(0, 5) == 0);
         step();
         n_tests++; if (spawn_valid !== 1'(m_offer) || active_count !== 4'(m_live)) begin n_fail++; $display("FAIL rand_core%0d: got v=%0b count=%0d exp %0b,%0d", k, spawn_valid, active_count, m_offer, m_live); end
         n_tests++; if (spawn_skip !== m_skip || retry_fail !== m_fail || dbg_state !== exp_dbg()) begin n_fail++; $display("FAIL rand_status%0d: got s=%0b f=%0b st=%0d exp %0b,%0b,%0d", k, spawn_skip, retry_fail, dbg_state, m_skip, m_fail, exp_dbg()); end
         if (m_offer) begin
            n_tests++; if (exp_q.size() == 0 || {spawn_x, spawn_y} !== exp_q[0]) begin n_fail++; $display("FAIL rand_xy%0d: got %0d,%0d exp %h", k, spawn_x, spawn_y, (exp_q.size() > 0) ? exp_q[0] : 11'h0); end
         end
      end
      tick = 1'b0; collected = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, exp normal completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      test_reset();
      test_basic();
      test_retry();
      test_retry_fail();
      test_offer_hold();
      test_full_skip();
      test_reset_offer();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
